mor1kx_bus_arbiter: RTL and testbench
=====================================

Name: mor1kx_bus_arbiter

Overview:
- Next-generation CPU bus adapter for the mor1kx core.
- Accepts the core's two Wishbone B3 registered-feedback masters (instruction and data) and arbitrates them onto one shared chip-select CPU bus (cs/we/sel/adr/dat/ack).
- Adds configurable arbitration, incrementing-burst grant retention, an ack timeout that returns a Wishbone error, and registered read data.
- Sits between the mor1kx instance and the system memory/peripheral bus controller.

Parameters:
- AW, 24, CPU bus address width; master addresses are truncated to [AW-1:0].
- ARB_MODE, "DATA", arbitration policy: "DATA" gives the data master fixed priority; "RR" alternates on contention.
- TIMEOUT, 255, cycles in BUSY without cpu_ack before an error is returned; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_adr_i  in  32  instruction master address
- i_cyc_i, i_stb_i, i_we_i  in  1 each  instruction master Wishbone controls
- i_sel_i  in  4  instruction byte select
- i_cti_i  in  3  instruction cycle type
- i_dat_i  in  32  instruction write data
- i_dat_o  out  32  instruction read data
- i_ack_o, i_err_o  out  1 each  instruction ack / error
- d_adr_i, d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_cti_i, d_dat_i, d_dat_o, d_ack_o, d_err_o: data master, same widths and meanings as the i_ set
- cpu_cs  out  1  bus request
- cpu_we  out  1  write enable
- cpu_sel  out  4  byte select
- cpu_adr  out  AW  address
- cpu_dat_w  out  32  write data
- cpu_dat_r  in  32  read data
- cpu_ack  in  1  transfer done
- grant_o  out  2  current owner: 01 = instruction, 10 = data, 00 = none
- bus_err_o  out  1  one-cycle pulse on each timeout

Behaviour:
- Single clock. Reset is asynchronous and active-low; all state is cleared immediately on rst_n low.
- Reset values:
  - state IDLE, grant_o 0, cpu_cs 0.
  - All ack/err outputs 0; read-data register 0.
  - Timeout counter 0; last-grant = instruction.
- Request definition: req_x = x_cyc_i & x_stb_i.
- State IDLE:
  - If any request is pending, register the grant and go to BUSY next cycle.
  - "DATA" mode: the data master wins whenever req_d.
  - "RR" mode: a sole requester wins; on contention the master opposite last-grant wins. First contention after reset therefore goes to data.
- State BUSY:
  - cpu_cs = 1. cpu_we/sel/adr/dat_w are combinationally muxed from the granted master; they are 0 in other states.
  - Counter increments each BUSY cycle.
  - On cpu_ack: latch cpu_dat_r into the read register, update last-grant, go to RESP_OK.
  - If the counter reaches TIMEOUT-1 with no cpu_ack (and TIMEOUT != 0): read register = 0, pulse bus_err_o, go to RESP_ERR.
  - If the granted master drops cyc: go to IDLE; a cpu_ack in that cycle is discarded.
- State RESP_OK / RESP_ERR:
  - cpu_cs = 0. Assert granted x_ack_o (or x_err_o) for exactly one cycle; both x_dat_o carry the read register. Counter clears.
  - Next state: if the beat was accepted with x_cti_i == 3'b010 and the master's cyc is still high, return to BUSY with the same grant (burst lock). Otherwise go to IDLE.
- Latency:
  - Request to cpu_cs: 1 cycle.
  - cpu_ack to master ack: 1 cycle.
  - Minimum 3 cycles per non-burst transfer; bursts sustain 2 cycles per beat.
- Never more than one master ack/err per cycle. cpu_cs is never high in the cycle after cpu_ack.
- A request from the losing master waits in IDLE-order until the grant is released; no starvation in "RR" mode.
- cpu_ack outside BUSY is ignored.

Test Plan:
- Single data read: d_adr 0x00001234, cpu_ack after 2 BUSY cycles with 0xDEADBEEF -> cpu_adr 0x001234; d_ack_o high 1 cycle after cpu_ack; d_dat_o 0xDEADBEEF; i_ack_o stays 0.
- Simultaneous requests, ARB_MODE "RR", 3 back-to-back transfers from each master -> grant_o sequence 10,01,10,01,10,01. With "DATA" mode -> all three data transfers complete first.
- Instruction burst: i_cti_i 010 for 4 beats, 111 on the last, d requesting throughout -> grant_o stays 01 for all 4 beats; data granted only after the final beat; 2 cycles per beat.
- Timeout, TIMEOUT 8, no cpu_ack -> d_err_o and bus_err_o pulse in the cycle after the 8th BUSY cycle; d_dat_o 0; state returns to IDLE. With TIMEOUT 0 -> cs held indefinitely.
- Abort: d_cyc_i dropped in the 2nd BUSY cycle with cpu_ack simultaneously high -> no d_ack_o; cpu_cs low next cycle; grant_o 00.
- rst_n asserted mid-BUSY -> cpu_cs, grant_o and acks go to 0 immediately without waiting for a clock edge. After release, the first request is granted normally.

Source files
------------

// File: rtl/mor1kx_bus_arbiter.sv
// Arbitrates the mor1kx instruction and data Wishbone masters onto one
// chip-select CPU bus, with burst grant retention, ack timeout and registered read data.
module mor1kx_bus_arbiter #(
   parameter int    AW       = 24,
   parameter string ARB_MODE = "DATA",
   parameter int    TIMEOUT  = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   i_adr_i,
   input  logic          i_cyc_i,
   input  logic          i_stb_i,
   input  logic          i_we_i,
   input  logic [3:0]    i_sel_i,
   input  logic [2:0]    i_cti_i,
   input  logic [31:0]   i_dat_i,
   output logic [31:0]   i_dat_o,
   output logic          i_ack_o,
   output logic          i_err_o,
   input  logic [31:0]   d_adr_i,
   input  logic          d_cyc_i,
   input  logic          d_stb_i,
   input  logic          d_we_i,
   input  logic [3:0]    d_sel_i,
   input  logic [2:0]    d_cti_i,
   input  logic [31:0]   d_dat_i,
   output logic [31:0]   d_dat_o,
   output logic          d_ack_o,
   output logic          d_err_o,
   output logic          cpu_cs,
   output logic          cpu_we,
   output logic [3:0]    cpu_sel,
   output logic [AW-1:0] cpu_adr,
   output logic [31:0]   cpu_dat_w,
   input  logic [31:0]   cpu_dat_r,
   input  logic          cpu_ack,
   output logic [1:0]    grant_o,
   output logic          bus_err_o
);

   localparam bit RR_MODE = (ARB_MODE == "RR");
   localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP_OK, RESP_ERR} state_t;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_req_t;

   state_t        state, state_nxt;
   wb_req_t       im, dm, gm;
   logic [1:0]    grant;
   logic          last_d;
   logic [CW-1:0] cnt;
   logic [31:0]   rdata;
   logic          req_i, req_d, pick_d, burst, timeout_hit;
   logic          unused_bits;

   assign im = '{cyc: i_cyc_i, stb: i_stb_i, we: i_we_i, sel: i_sel_i,
                 cti: i_cti_i, adr: i_adr_i, dat: i_dat_i};
   assign dm = '{cyc: d_cyc_i, stb: d_stb_i, we: d_we_i, sel: d_sel_i,
                 cti: d_cti_i, adr: d_adr_i, dat: d_dat_i};
   assign gm = grant[1] ? dm : im;

   assign req_i = im.cyc & im.stb;
   assign req_d = dm.cyc & dm.stb;
   // RR: on contention the master opposite the last completed owner wins
   assign pick_d      = RR_MODE ? (req_d & (!req_i | !last_d)) : req_d;
   assign burst       = gm.cyc & (gm.cti == 3'b010);
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign unused_bits = ^{gm};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (req_i | req_d) state_nxt = BUSY;
         // a dropped cyc wins over a same-cycle ack, which is then discarded
         BUSY: begin
            if (!gm.cyc)          state_nxt = IDLE;
            else if (cpu_ack)     state_nxt = RESP_OK;
            else if (timeout_hit) state_nxt = RESP_ERR;
         end
         RESP_OK, RESP_ERR: state_nxt = burst ? BUSY : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cpu_cs    = 1'b0;
      cpu_we    = 1'b0;
      cpu_sel   = '0;
      cpu_adr   = '0;
      cpu_dat_w = '0;
      i_ack_o   = 1'b0;
      i_err_o   = 1'b0;
      d_ack_o   = 1'b0;
      d_err_o   = 1'b0;
      bus_err_o = 1'b0;
      case (state)
         BUSY: begin
            cpu_cs    = 1'b1;
            cpu_we    = gm.we;
            cpu_sel   = gm.sel;
            cpu_adr   = gm.adr[AW-1:0];
            cpu_dat_w = gm.dat;
         end
         RESP_OK: begin
            i_ack_o = grant[0];
            d_ack_o = grant[1];
         end
         RESP_ERR: begin
            i_err_o   = grant[0];
            d_err_o   = grant[1];
            bus_err_o = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant  <= '0;
         last_d <= 1'b0;
         cnt    <= '0;
         rdata  <= '0;
      end else begin
         if (state_nxt == IDLE)
            grant <= '0;
         else if (state == IDLE)
            grant <= pick_d ? 2'b10 : 2'b01;

         if (state == BUSY) cnt <= cnt + 1'b1;
         else               cnt <= '0;

         if (state == BUSY && gm.cyc) begin
            if (cpu_ack) begin
               rdata  <= cpu_dat_r;
               last_d <= grant[1];
            end else if (timeout_hit) begin
               rdata  <= '0;
            end
         end
      end
   end

   assign grant_o = grant;
   assign i_dat_o = rdata;
   assign d_dat_o = rdata;

endmodule

// File: tb/tb_mor1kx_bus_arbiter.sv
// Scoreboard bench: instance A (RR, TIMEOUT 8) and instance B (DATA, TIMEOUT 0)
// share master stimulus; sel_b chooses which one the responder and monitor follow.
module tb_mor1kx_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] i_adr_i, d_adr_i, i_dat_i, d_dat_i, cpu_dat_r;
   logic        i_cyc_i, i_stb_i, i_we_i, d_cyc_i, d_stb_i, d_we_i, cpu_ack;
   logic [3:0]  i_sel_i, d_sel_i;
   logic [2:0]  i_cti_i, d_cti_i;

   logic [31:0] a_i_dat, a_d_dat, b_i_dat, b_d_dat, a_datw, b_datw;
   logic        a_i_ack, a_i_err, a_d_ack, a_d_err, b_i_ack, b_i_err, b_d_ack, b_d_err;
   logic        a_cs, a_we, b_cs, b_we, a_berr, b_berr;
   logic [3:0]  a_sel, b_sel;
   logic [23:0] a_adr, b_adr;
   logic [1:0]  a_gnt, b_gnt;

   mor1kx_bus_arbiter #(.AW(24), .ARB_MODE("RR"), .TIMEOUT(8)) u_a (
      .clk(clk), .rst_n(rst_n),
      .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i),
      .i_sel_i(i_sel_i), .i_cti_i(i_cti_i), .i_dat_i(i_dat_i), .i_dat_o(a_i_dat),
      .i_ack_o(a_i_ack), .i_err_o(a_i_err),
      .d_adr_i(d_adr_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
      .d_sel_i(d_sel_i), .d_cti_i(d_cti_i), .d_dat_i(d_dat_i), .d_dat_o(a_d_dat),
      .d_ack_o(a_d_ack), .d_err_o(a_d_err),
      .cpu_cs(a_cs), .cpu_we(a_we), .cpu_sel(a_sel), .cpu_adr(a_adr), .cpu_dat_w(a_datw),
      .cpu_dat_r(cpu_dat_r), .cpu_ack(cpu_ack), .grant_o(a_gnt), .bus_err_o(a_berr));

   mor1kx_bus_arbiter #(.AW(24), .ARB_MODE("DATA"), .TIMEOUT(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i),
      .i_sel_i(i_sel_i), .i_cti_i(i_cti_i), .i_dat_i(i_dat_i), .i_dat_o(b_i_dat),
      .i_ack_o(b_i_ack), .i_err_o(b_i_err),
      .d_adr_i(d_adr_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
      .d_sel_i(d_sel_i), .d_cti_i(d_cti_i), .d_dat_i(d_dat_i), .d_dat_o(b_d_dat),
      .d_ack_o(b_d_ack), .d_err_o(b_d_err),
      .cpu_cs(b_cs), .cpu_we(b_we), .cpu_sel(b_sel), .cpu_adr(b_adr), .cpu_dat_w(b_datw),
      .cpu_dat_r(cpu_dat_r), .cpu_ack(cpu_ack), .grant_o(b_gnt), .bus_err_o(b_berr));

   bit sel_b = 1'b0;
   wire [31:0] s_i_dat = sel_b ? b_i_dat : a_i_dat;
   wire [31:0] s_d_dat = sel_b ? b_d_dat : a_d_dat;
   wire [31:0] s_datw  = sel_b ? b_datw  : a_datw;
   wire        s_i_ack = sel_b ? b_i_ack : a_i_ack;
   wire        s_i_err = sel_b ? b_i_err : a_i_err;
   wire        s_d_ack = sel_b ? b_d_ack : a_d_ack;
   wire        s_d_err = sel_b ? b_d_err : a_d_err;
   wire        s_cs    = sel_b ? b_cs    : a_cs;
   wire        s_we    = sel_b ? b_we    : a_we;
   wire        s_berr  = sel_b ? b_berr  : a_berr;
   wire [3:0]  s_sel   = sel_b ? b_sel   : a_sel;
   wire [23:0] s_adr   = sel_b ? b_adr   : a_adr;
   wire [1:0]  s_gnt   = sel_b ? b_gnt   : a_gnt;

   int total = 0;
   int bad   = 0;
   int cycn  = 0;
   always @(posedge clk) cycn <= cycn + 1;

   typedef struct { bit src; bit err; logic [31:0] dat; } exp_t;
   exp_t sb[$];
   int   ack_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input bit src, input bit err, input logic [31:0] dat);
      exp_t e;
      e.src = src; e.err = err; e.dat = dat;
      sb.push_back(e);
   endtask

   // responder: ack in the resp_lat-th cs cycle (0 = never)
   int          resp_lat = 1;
   int          bcnt = 0;
   int          busy_len = 0;
   int          cpu_ack_cyc = 0;
   logic [23:0] last_adr = '0;
   logic        last_we = 1'b0;
   logic [31:0] last_datw = '0;
   logic [3:0]  last_sel = '0;
   initial begin cpu_ack = 1'b0; cpu_dat_r = '0; end

   function automatic logic [31:0] rd_of(input logic [23:0] a);
      return (a == 24'h001234) ? 32'hDEADBEEF : {8'h5A, a};
   endfunction

   always @(negedge clk) begin
      if (rst_n && cpu_ack && s_cs) chk("cs_after_ack", {31'd0, s_cs}, 32'd0);
      if (s_cs) begin
         bcnt = bcnt + 1;
         if (resp_lat != 0 && bcnt == resp_lat) begin
            cpu_ack = 1'b1;
            cpu_dat_r = rd_of(s_adr);
            last_adr = s_adr; last_we = s_we; last_datw = s_datw; last_sel = s_sel;
            cpu_ack_cyc = cycn;
         end else cpu_ack = 1'b0;
      end else begin
         if (bcnt != 0) busy_len = bcnt;
         bcnt = 0;
         cpu_ack = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if ((s_i_ack | s_i_err) && (s_d_ack | s_d_err)) begin
            total++; bad++;
            $display("FAIL dual_ack: got both masters acked want one");
         end else if (s_i_ack | s_i_err | s_d_ack | s_d_err) begin
            bit act_src, act_err;
            logic [31:0] act_dat;
            act_src = s_d_ack | s_d_err;
            act_err = s_i_err | s_d_err;
            act_dat = act_src ? s_d_dat : s_i_dat;
            ack_cyc.push_back(cycn);
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ack: got src=%0d err=%0d dat=%h want none", act_src, act_err, act_dat);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (act_src !== e.src || act_err !== e.err || act_dat !== e.dat ||
                   s_i_dat !== s_d_dat || s_gnt !== (e.src ? 2'b10 : 2'b01) || s_berr !== e.err) begin
                  bad++;
                  $display("FAIL resp: got src=%0d err=%0d dat=%h gnt=%b berr=%0d want src=%0d err=%0d dat=%h",
                           act_src, act_err, act_dat, s_gnt, s_berr, e.src, e.err, e.dat);
               end
            end
         end
      end
   end

   task automatic xfer(input bit dm, input logic [31:0] adr, input bit we,
                       input logic [31:0] dat, input logic [2:0] cti, input bit last);
      int n;
      bit got;
      if (dm) begin
         d_cyc_i = 1; d_stb_i = 1; d_adr_i = adr; d_we_i = we; d_dat_i = dat; d_cti_i = cti; d_sel_i = 4'hF;
      end else begin
         i_cyc_i = 1; i_stb_i = 1; i_adr_i = adr; i_we_i = we; i_dat_i = dat; i_cti_i = cti; i_sel_i = 4'hF;
      end
      n = 0; got = 0;
      while (!got) begin
         @(negedge clk);
         if (dm ? (s_d_ack | s_d_err) : (s_i_ack | s_i_err)) got = 1;
         @(posedge clk); #1;
         n++;
         if (!got && n > 400) begin
            total++; bad++;
            $display("FAIL xfer_timeout: got no ack for adr %h want ack", adr);
            break;
         end
      end
      if (last) begin
         if (dm) begin d_cyc_i = 0; d_stb_i = 0; d_cti_i = 0; d_we_i = 0; end
         else    begin i_cyc_i = 0; i_stb_i = 0; i_cti_i = 0; i_we_i = 0; end
      end
   endtask

   task automatic clr_masters();
      i_cyc_i = 0; i_stb_i = 0; i_we_i = 0; i_sel_i = 0; i_cti_i = 0; i_adr_i = 0; i_dat_i = 0;
      d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; d_sel_i = 0; d_cti_i = 0; d_adr_i = 0; d_dat_i = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0;
      clr_masters();
      #10 rst_n = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_masters();
      #2;
      chk("rst_cs_a",   {31'd0, a_cs}, 0);
      chk("rst_gnt_a",  {30'd0, a_gnt}, 0);
      chk("rst_acks_a", {28'd0, a_i_ack, a_i_err, a_d_ack, a_d_err}, 0);
      chk("rst_berr_a", {31'd0, a_berr}, 0);
      chk("rst_dat_a",  a_d_dat, 0);
      chk("rst_cs_b",   {31'd0, b_cs}, 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // single data read, upper address bits truncated
      resp_lat = 2;
      push(1, 0, 32'hDEADBEEF);
      xfer(1, 32'hFF001234, 0, 0, 3'b000, 1);
      chk("rd_adr", {8'd0, last_adr}, 32'h001234);
      chk("rd_lat", ack_cyc[$] - cpu_ack_cyc, 1);
      chk("rd_busy_len", busy_len, 2);

      // single data write
      resp_lat = 1;
      push(1, 0, 32'h5A000040);
      xfer(1, 32'h40, 1, 32'hCAFEF00D, 3'b000, 1);
      chk("wr_we", {31'd0, last_we}, 1);
      chk("wr_dat", last_datw, 32'hCAFEF00D);
      chk("wr_sel", {28'd0, last_sel}, 4'hF);

      // RR contention from reset: d,i,d,i,d,i
      do_reset();
      push(1, 0, 32'h5A000200); push(0, 0, 32'h5A000100);
      push(1, 0, 32'h5A000204); push(0, 0, 32'h5A000104);
      push(1, 0, 32'h5A000208); push(0, 0, 32'h5A000108);
      fork
         begin xfer(0, 32'h100, 0, 0, 3'b000, 0); xfer(0, 32'h104, 0, 0, 3'b000, 0); xfer(0, 32'h108, 0, 0, 3'b000, 1); end
         begin xfer(1, 32'h200, 0, 0, 3'b000, 0); xfer(1, 32'h204, 0, 0, 3'b000, 0); xfer(1, 32'h208, 0, 0, 3'b000, 1); end
      join

      // instruction burst holds the grant while data waits
      ack_cyc.delete();
      push(0, 0, 32'h5A000400); push(0, 0, 32'h5A000404);
      push(0, 0, 32'h5A000408); push(0, 0, 32'h5A00040C);
      push(1, 0, 32'h5A000300);
      fork
         begin
            xfer(0, 32'h400, 0, 0, 3'b010, 0); xfer(0, 32'h404, 0, 0, 3'b010, 0);
            xfer(0, 32'h408, 0, 0, 3'b010, 0); xfer(0, 32'h40C, 0, 0, 3'b111, 1);
         end
         begin @(posedge clk); #1; xfer(1, 32'h300, 0, 0, 3'b000, 1); end
      join
      for (int k = 1; k < 4; k++) chk("burst_beat", ack_cyc[k] - ack_cyc[k-1], 2);

      // timeout after 8 BUSY cycles
      resp_lat = 0;
      push(1, 1, 32'h0);
      xfer(1, 32'h500, 0, 0, 3'b000, 1);
      chk("to_busy_len", busy_len, 8);
      @(negedge clk);
      chk("to_idle_gnt", {30'd0, a_gnt}, 0);
      chk("to_idle_cs", {31'd0, a_cs}, 0);

      // abort: cyc dropped in 2nd BUSY cycle with cpu_ack high
      resp_lat = 2;
      @(posedge clk); #1;
      d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h600; d_cti_i = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      d_cyc_i = 0; d_stb_i = 0;
      @(negedge clk); #1;
      chk("ab_ack_in", {31'd0, cpu_ack}, 1);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("ab_cs", {31'd0, a_cs}, 0);
      chk("ab_gnt", {30'd0, a_gnt}, 0);
      chk("ab_dack", {31'd0, a_d_ack}, 0);
      repeat (3) @(posedge clk);
      #1;

      // async reset in the middle of BUSY
      resp_lat = 0;
      d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h680;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("ar_busy", {31'd0, a_cs}, 1);
      rst_n = 0;
      #1;
      chk("ar_cs", {31'd0, a_cs}, 0);
      chk("ar_gnt", {30'd0, a_gnt}, 0);
      chk("ar_acks", {28'd0, a_i_ack, a_i_err, a_d_ack, a_d_err}, 0);
      clr_masters();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      resp_lat = 1;
      push(1, 0, 32'h5A000700);
      xfer(1, 32'h700, 0, 0, 3'b000, 1);

      // instance B: DATA priority, then no timeout
      sel_b = 1;
      do_reset();
      push(1, 0, 32'h5A000200); push(1, 0, 32'h5A000204); push(1, 0, 32'h5A000208);
      push(0, 0, 32'h5A000100); push(0, 0, 32'h5A000104); push(0, 0, 32'h5A000108);
      fork
         begin xfer(0, 32'h100, 0, 0, 3'b000, 0); xfer(0, 32'h104, 0, 0, 3'b000, 0); xfer(0, 32'h108, 0, 0, 3'b000, 1); end
         begin xfer(1, 32'h200, 0, 0, 3'b000, 0); xfer(1, 32'h204, 0, 0, 3'b000, 0); xfer(1, 32'h208, 0, 0, 3'b000, 1); end
      join
      resp_lat = 0;
      d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h800;
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("t0_cs_held", {31'd0, b_cs}, 1);
      chk("t0_no_err", {31'd0, b_berr | b_d_err}, 0);
      @(posedge clk); #1;
      d_cyc_i = 0; d_stb_i = 0;
      @(posedge clk); #1;
      chk("t0_cs_drop", {31'd0, b_cs}, 0);

      repeat (3) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
